// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: owns the program counter, the IDLE/RUN/DONE
// sequencing, the retired-instruction counter and a sticky PC wrap flag.
module fetch_ctrl #(
   parameter int A  = 10,
   parameter int OW = 6
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          Start,
   input  logic [A-1:0]  StartAddr,
   input  logic          Stall,
   input  logic          Halt,
   input  logic          Jump,
   input  logic [A-1:0]  Target,
   input  logic          Branch,
   input  logic [OW-1:0] Offset,
   output logic [A-1:0]  InstAddress,
   output logic          Running,
   output logic          Done,
   output logic [15:0]   InstCount,
   output logic          Wrapped
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [A-1:0]  pc_q, pc_d;
   logic [15:0]   count_q, count_d;
   logic          wrapped_q, wrapped_d;
   logic [A-1:0]  offset_ext;

   assign offset_ext = {{(A-OW){Offset[OW-1]}}, Offset};

   // NOTE: every *_d gets its current value first so no path through the case leaves it unassigned (no latches).
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      count_d   = count_q;
      wrapped_d = wrapped_q;

      unique case (state_q)
         IDLE, DONE: begin
            if (Start) begin
               state_d   = RUN;
               pc_d      = StartAddr;
               count_d   = '0;
               wrapped_d = 1'b0;
            end
         end
         RUN: begin
            if (!Stall) begin
               // Halt retires too, so counting happens before the control decode.
               if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
               if (Halt) begin
                  state_d = DONE;
               end else if (Jump) begin
                  pc_d = Target;
               end else if (Branch) begin
                  pc_d = pc_q + offset_ext;
               end else begin
                  pc_d = pc_q + 1'b1;
                  if (&pc_q) wrapped_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only; the async clear is in the sensitivity list.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q   <= IDLE;
         pc_q      <= '0;
         count_q   <= '0;
         wrapped_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         count_q   <= count_d;
         wrapped_q <= wrapped_d;
      end
   end

   assign InstAddress = pc_q;
   assign Running     = (state_q == RUN);
   assign Done        = (state_q == DONE);
   assign InstCount   = count_q;
   assign Wrapped     = wrapped_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed plus randomized bench for fetch_ctrl, checked against an
// arithmetic reference model of the fetch rules.
module tb_fetch_ctrl;

   localparam int A   = 10;
   localparam int OW  = 6;
   localparam int MOD = 1 << A;

   logic          Clk = 1'b0;
   logic          Reset = 1'b0;
   logic          Start = 1'b0;
   logic [A-1:0]  StartAddr = '0;
   logic          Stall = 1'b0;
   logic          Halt = 1'b0;
   logic          Jump = 1'b0;
   logic [A-1:0]  Target = '0;
   logic          Branch = 1'b0;
   logic [OW-1:0] Offset = '0;
   logic [A-1:0]  InstAddress;
   logic          Running;
   logic          Done;
   logic [15:0]   InstCount;
   logic          Wrapped;

   fetch_ctrl #(.A(A), .OW(OW)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
      .Stall(Stall), .Halt(Halt), .Jump(Jump), .Target(Target),
      .Branch(Branch), .Offset(Offset), .InstAddress(InstAddress),
      .Running(Running), .Done(Done), .InstCount(InstCount), .Wrapped(Wrapped)
   );

   always #5 Clk = ~Clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: plain integers, one "executing" flag and one "finished" flag.
   int m_pc, m_cnt;
   bit m_exec, m_fin, m_wrap;

   task automatic model_reset();
      m_pc = 0; m_cnt = 0; m_exec = 0; m_fin = 0; m_wrap = 0;
   endtask

   task automatic model_edge();
      int off;
      if (!Reset) begin
         model_reset();
      end else if (!m_exec) begin
         if (Start) begin
            m_exec = 1; m_fin = 0; m_pc = int'(StartAddr); m_cnt = 0; m_wrap = 0;
         end
      end else if (!Stall) begin
         m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
         off = Offset[OW-1] ? int'(Offset) - (1 << OW) : int'(Offset);
         if (Halt) begin
            m_exec = 0; m_fin = 1;
         end else if (Jump) begin
            m_pc = int'(Target);
         end else if (Branch) begin
            m_pc = (m_pc + off + MOD) % MOD;
         end else begin
            if (m_pc == MOD - 1) m_wrap = 1;
            m_pc = (m_pc + 1) % MOD;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".pc"},      32'(InstAddress), 32'(m_pc));
      chk({tag, ".running"}, 32'(Running),     32'(m_exec));
      chk({tag, ".done"},    32'(Done),        32'(m_fin));
      chk({tag, ".count"},   32'(InstCount),   32'(m_cnt));
      chk({tag, ".wrapped"}, 32'(Wrapped),     32'(m_wrap));
   endtask

   task automatic clear_ctl();
      Start = 0; Stall = 0; Halt = 0; Jump = 0; Branch = 0;
   endtask

   // One rising edge; inputs are already set, outputs sampled 1 time unit later.
   task automatic tick(input string tag);
      model_edge();
      @(posedge Clk);
      #1;
      check_all(tag);
   endtask

   initial begin
      model_reset();
      #1;
      check_all("reset_async");
      Start = 1; StartAddr = 10'd77;
      tick("start_in_reset");           // ignored while Reset is low
      #2 Reset = 1;
      clear_ctl();
      tick("idle_after_reset");

      // Sequential fetch from 5
      Start = 1; StartAddr = 10'd5;
      tick("start5");
      chk("start5.pc_const", 32'(InstAddress), 32'd5);
      clear_ctl();
      for (int i = 0; i < 4; i++) tick("seq");
      chk("seq.pc9", 32'(InstAddress), 32'd9);
      chk("seq.cnt4", 32'(InstCount), 32'd4);

      // Branch back by 4 from 12, then jump to 300
      Jump = 1; Target = 10'd12; tick("jump12"); clear_ctl();
      Branch = 1; Offset = 6'b111100; tick("branch_m4"); clear_ctl();
      chk("branch_m4.pc8", 32'(InstAddress), 32'd8);
      Jump = 1; Target = 10'd300; Branch = 1; tick("jump300"); clear_ctl();
      chk("jump300.pc", 32'(InstAddress), 32'd300);

      // Stall dominates Halt and Jump
      Jump = 1; Target = 10'd20; tick("jump20");
      Stall = 1; Halt = 1; Jump = 1; Target = 10'd99;
      for (int i = 0; i < 3; i++) tick("stall");
      Stall = 0; Jump = 0;
      tick("halt");
      chk("halt.done", 32'(Done), 32'd1);
      chk("halt.pc20", 32'(InstAddress), 32'd20);
      clear_ctl();
      Jump = 1; Branch = 1; Target = 10'd3; tick("done_ignores_ctl"); clear_ctl();

      // Wrap-around from the top of the address space
      Start = 1; StartAddr = 10'd1022; tick("start1022"); clear_ctl();
      for (int i = 0; i < 3; i++) tick("wrap");
      chk("wrap.flag", 32'(Wrapped), 32'd1);

      // Start during RUN is ignored
      Start = 1; StartAddr = 10'd500;
      for (int i = 0; i < 2; i++) tick("start_in_run");
      clear_ctl();

      // Reset pulse mid-run at PC 40
      Jump = 1; Target = 10'd40; tick("jump40"); clear_ctl();
      #2 Reset = 0;
      model_reset();
      #1;
      check_all("reset_midrun");
      chk("reset_midrun.pc0", 32'(InstAddress), 32'd0);
      #1 Reset = 1;
      Start = 1; StartAddr = 10'd123;
      tick("restart_after_reset");
      clear_ctl();

      // Halt, then restart from 0 in DONE
      Halt = 1; tick("halt2"); clear_ctl();
      Start = 1; StartAddr = 10'd0; tick("start_from_done"); clear_ctl();
      chk("start_from_done.cnt0", 32'(InstCount), 32'd0);

      // Randomized controls against the model
      for (int i = 0; i < 600; i++) begin
         Start     = ($urandom_range(0, 9) == 0);
         StartAddr = A'($urandom_range(0, MOD - 1));
         Stall     = ($urandom_range(0, 4) == 0);
         Halt      = ($urandom_range(0, 19) == 0);
         Jump      = ($urandom_range(0, 7) == 0);
         Target    = A'($urandom_range(0, MOD - 1));
         Branch    = ($urandom_range(0, 3) == 0);
         Offset    = OW'($urandom_range(0, (1 << OW) - 1));
         tick("rand");
      end
      clear_ctl();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter A, default 10, width of the instruction address (program counter).
REQ-002 SHALL have parameter OW, default 6, width of the signed relative branch offset.
REQ-003 SHALL have port Clk, input, 1, single clock; all state changes on rising edge.
REQ-004 SHALL have port Reset, input, 1, asynchronous, active-low reset.
REQ-005 SHALL have port Start, input, 1, begin execution at StartAddr.
REQ-006 SHALL have port StartAddr, input, A, first instruction address.
REQ-007 SHALL have port Stall, input, 1, freeze fetch this cycle.
REQ-008 SHALL have port Halt, input, 1, current instruction is a halt.
REQ-009 SHALL have port Jump, input, 1, absolute jump to Target.
REQ-010 SHALL have port Target, input, A, absolute jump address.
REQ-011 SHALL have port Branch, input, 1, taken relative branch by Offset.
REQ-012 SHALL have port Offset, input, OW, two's-complement branch displacement.
REQ-013 SHALL have port InstAddress, output, A, registered PC driven to the instruction ROM address.
REQ-014 SHALL have port Running, output, 1, high in RUN.
REQ-015 SHALL have port Done, output, 1, high in DONE.
REQ-016 SHALL have port InstCount, output, 16, retired-instruction count.
REQ-017 SHALL have port Wrapped, output, 1, sticky PC wrap-around flag.

Function
REQ-018 SHALL implement states IDLE, RUN, DONE; Running/Done decoded directly from state register.
REQ-019 SHALL treat the ROM as combinational: the instruction at InstAddress and the decoded Halt/Jump/Branch are valid in the same cycle and act on the next rising edge.
REQ-020 SHALL, in IDLE or DONE with Start=1: go to RUN, PC<=StartAddr, InstCount<=0, Wrapped<=0.
REQ-021 SHALL ignore Start while in RUN.
REQ-022 SHALL ignore Stall, Halt, Jump, Branch outside RUN; PC holds.
REQ-023 SHALL, in RUN, apply priority Stall > Halt > Jump > Branch > sequential increment.
REQ-024 SHALL, on Stall=1 in RUN: hold PC, state, and InstCount.
REQ-025 SHALL, on Halt=1 (no Stall): go to DONE, hold PC at the halt address, count the halt as retired.
REQ-026 SHALL, on Jump=1: PC<=Target.
REQ-027 SHALL, on Branch=1: PC<=PC+sign-extended Offset, modulo 2^A; no Wrapped update.
REQ-028 SHALL, otherwise: PC<=PC+1 modulo 2^A; set Wrapped when PC goes from 2^A-1 to 0.
REQ-029 SHALL increment InstCount once per non-stalled RUN cycle, saturating at 16'hFFFF.
REQ-030 SHALL hold InstCount and Wrapped stable in DONE until the next Start.

Reset
REQ-031 SHALL, while Reset=0, asynchronously force: state IDLE, InstAddress 0, InstCount 0, Wrapped 0, Running 0, Done 0.
REQ-032 SHALL abort any RUN immediately on Reset assertion; after deassertion remain in IDLE until Start.
REQ-033 SHALL not act on Start sampled in the first edge while Reset=0.

Verification
REQ-034 SHALL cover: Start with StartAddr=5, no controls, 4 cycles -> InstAddress 5,6,7,8,9; InstCount 4 after the 4th edge.
REQ-035 SHALL cover: at PC=12, Branch=1, Offset=6'b111100 (-4) -> next PC 8; at PC=8, Jump=1, Target=300 -> next PC 300.
REQ-036 SHALL cover: Stall=1 with Jump=1 and Halt=1 at PC=20 for 3 cycles -> PC 20, InstCount unchanged; Stall drops with Halt=1 -> DONE, Done=1, PC 20, InstCount +1.
REQ-037 SHALL cover: StartAddr=1022 (A=10), run 3 cycles -> PC 1022,1023,0,1; Wrapped=1 from the edge reaching 0.
REQ-038 SHALL cover: Reset pulsed low mid-RUN at PC=40 -> InstAddress 0, state IDLE immediately; Start asserted in the first post-reset cycle -> RUN from StartAddr.
REQ-039 SHALL cover: Start held high during RUN -> no restart; Start in DONE with StartAddr=0 -> RUN, InstCount 0, Wrapped 0.
